one_hot_register_file: RTL and testbench

ONE_HOT_REGISTER_FILE -- requirements
Module: one_hot_register_file

---
 rtl/one_hot_register_file.sv | 92 +++++++++
 tb/tb_one_hot_register_file.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/one_hot_register_file.sv
// 16-entry register file written through a one-hot enable bus.
// Reads are registered on both ports, with a same-cycle write bypass.
// A sticky error flag records any enable pattern with more than one bit set.
// A wrapping 8-bit counter tracks the number of accepted writes.
module one_hot_register_file #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      wrEnable,
  input  logic [WIDTH-1:0] wrData,
  input  logic [3:0]       rdAddrA,
  input  logic [3:0]       rdAddrB,
  output logic [WIDTH-1:0] rdDataA,
  output logic [WIDTH-1:0] rdDataB,
  input  logic             clrErr,
  output logic             errFlag,
  output logic [7:0]       wrCount
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             is_zero;
  logic             is_multi;
  logic             is_onehot;
  logic [3:0]       wr_index;
  logic             bypass_a;
  logic             bypass_b;

  // Classify the enable bus.
  // Clearing the lowest set bit leaves a nonzero result only when two or more bits were set.
  always_comb begin
    is_zero   = (wrEnable == 16'd0);
    is_multi  = |(wrEnable & (wrEnable - 16'd1));
    is_onehot = !is_zero && !is_multi;
  end

  // Encode the one-hot enable into a register index (only meaningful when is_onehot).
  always_comb begin
    wr_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (wrEnable[i]) wr_index = i[3:0];
    end
  end

  // A read port takes the incoming write data when it addresses the register being written.
  always_comb begin
    bypass_a = is_onehot && wrEnable[rdAddrA];
    bypass_b = is_onehot && wrEnable[rdAddrB];
  end

  // Register storage: only a clean one-hot enable updates a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (is_onehot) begin
      regs[wr_index] <= wrData;
    end
  end

  // Registered read ports with write-through bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdDataA <= '0;
      rdDataB <= '0;
    end else begin
      rdDataA <= bypass_a ? wrData : regs[rdAddrA];
      rdDataB <= bypass_b ? wrData : regs[rdAddrB];
    end
  end

  // Sticky error flag: a MULTI pattern sets it and overrides a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      errFlag <= 1'b0;
    end else if (is_multi) begin
      errFlag <= 1'b1;
    end else if (clrErr) begin
      errFlag <= 1'b0;
    end
  end

  // Count accepted writes, wrapping from 255 back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrCount <= 8'd0;
    end else if (is_onehot) begin
      wrCount <= wrCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_one_hot_register_file.sv
// Self-checking bench for one_hot_register_file.
// A behavioural model predicts the outputs and pushes them to a scoreboard queue.
// Entries are popped and compared one cycle later, after the DUT has registered its outputs.
module tb_one_hot_register_file;

  logic        clk;
  logic        reset;
  logic [15:0] wrEnable;
  logic [15:0] wrData;
  logic [3:0]  rdAddrA;
  logic [3:0]  rdAddrB;
  logic [15:0] rdDataA;
  logic [15:0] rdDataB;
  logic        clrErr;
  logic        errFlag;
  logic [7:0]  wrCount;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_regs [16];
  logic        model_err;
  logic [7:0]  model_cnt;
  int          tests_run;
  int          fail_count;

  one_hot_register_file #(.WIDTH(16), .NREGS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .wrEnable (wrEnable),
    .wrData   (wrData),
    .rdAddrA  (rdAddrA),
    .rdAddrB  (rdAddrB),
    .rdDataA  (rdDataA),
    .rdDataB  (rdDataB),
    .clrErr   (clrErr),
    .errFlag  (errFlag),
    .wrCount  (wrCount)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against one required value.
  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest prediction and compare all outputs against it.
  task automatic checkOutput();
    exp_t e;
    tests_run++;
    assert (sb.size() > 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_empty: observed size 0, expected size >0");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkValue("rdDataA", rdDataA, e.a);
      checkValue("rdDataB", rdDataB, e.b);
      checkValue("errFlag", {15'd0, errFlag}, {15'd0, e.err});
      checkValue("wrCount", {8'd0, wrCount}, {8'd0, e.cnt});
    end
  endtask

  // Drive one cycle of inputs, predict the outputs after the next edge, then check them.
  task automatic applyStimulus(input logic [15:0] we, input logic [15:0] wd,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic clr, input logic rst);
    exp_t e;
    int   n;
    int   idx;
    wrEnable = we;
    wrData   = wd;
    rdAddrA  = ra;
    rdAddrB  = rb;
    clrErr   = clr;
    reset    = rst;
    n   = $countones(we);
    idx = 0;
    for (int i = 0; i < 16; i++) if (we[i]) idx = i;
    if (rst) begin
      for (int i = 0; i < 16; i++) model_regs[i] = 16'd0;
      model_err = 1'b0;
      model_cnt = 8'd0;
      e.a = 16'd0;
      e.b = 16'd0;
    end else begin
      e.a = (n == 1 && we[ra]) ? wd : model_regs[ra];
      e.b = (n == 1 && we[rb]) ? wd : model_regs[rb];
      if (n == 1) begin
        model_regs[idx] = wd;
        model_cnt = model_cnt + 8'd1;
      end
      if (n > 1) model_err = 1'b1;
      else if (clr) model_err = 1'b0;
    end
    e.err = model_err;
    e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Directed sequence followed by a short randomised phase.
  initial begin
    int k;
    int j;
    logic [15:0] we;
    tests_run  = 0;
    fail_count = 0;
    wrEnable = 16'd0;
    wrData   = 16'd0;
    rdAddrA  = 4'd0;
    rdAddrB  = 4'd0;
    clrErr   = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 16; i++) model_regs[i] = 16'd0;
    model_err = 1'b0;
    model_cnt = 8'd0;

    // Reset state
    applyStimulus(16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b1);
    applyStimulus(16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b1);
    checkValue("reset_rdDataA", rdDataA, 16'h0000);
    checkValue("reset_wrCount", {8'd0, wrCount}, 16'd0);

    // Reset then write, read back one cycle later
    applyStimulus(16'h0008, 16'hBEEF, 4'd0, 4'd1, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 4'd3, 4'd0, 1'b0, 1'b0);
    checkValue("write_readback", rdDataA, 16'hBEEF);
    checkValue("write_count", {8'd0, wrCount}, 16'd1);

    // Bypass on both ports to the same register
    applyStimulus(16'h0020, 16'h1234, 4'd5, 4'd5, 1'b0, 1'b0);
    checkValue("bypass_A", rdDataA, 16'h1234);
    checkValue("bypass_B", rdDataB, 16'h1234);

    // MULTI rejection and clear
    applyStimulus(16'h0001, 16'hAAAA, 4'd0, 4'd3, 1'b0, 1'b0);
    applyStimulus(16'h0003, 16'h5555, 4'd0, 4'd1, 1'b0, 1'b0);
    checkValue("multi_err", {15'd0, errFlag}, 16'd1);
    checkValue("multi_count", {8'd0, wrCount}, 16'd3);
    applyStimulus(16'h0000, 16'h0000, 4'd0, 4'd1, 1'b0, 1'b0);
    checkValue("multi_reg0_kept", rdDataA, 16'hAAAA);
    applyStimulus(16'h0000, 16'h0000, 4'd0, 4'd5, 1'b1, 1'b0);
    checkValue("clr_err", {15'd0, errFlag}, 16'd0);

    // Set wins over clear
    applyStimulus(16'h8001, 16'h0F0F, 4'd15, 4'd0, 1'b1, 1'b0);
    checkValue("set_wins", {15'd0, errFlag}, 16'd1);
    applyStimulus(16'h0000, 16'h0000, 4'd15, 4'd0, 1'b0, 1'b0);
    checkValue("set_wins_hold", {15'd0, errFlag}, 16'd1);

    // Randomised mix of ZERO, ONEHOT and MULTI cycles
    for (int r = 0; r < 60; r++) begin
      k = $urandom_range(0, 15);
      j = $urandom_range(0, 9);
      we = 16'd1 << k;
      if (j == 7) we = 16'd0;
      else if (j > 7) we = we | (16'd1 << ((k + 1 + $urandom_range(0, 13)) % 16));
      applyStimulus(we, 16'($urandom), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Counter wrap from zero
    applyStimulus(16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(16'd1 << (i % 16), 16'(i), 4'(i % 16), 4'((i + 3) % 16), 1'b0, 1'b0);
      if (i == 254) checkValue("count_255", {8'd0, wrCount}, 16'd255);
      if (i == 255) checkValue("count_wrap", {8'd0, wrCount}, 16'd0);
    end

    // Reset mid-operation discards the write and clears everything
    applyStimulus(16'h0100, 16'h7777, 4'd8, 4'd8, 1'b0, 1'b0);
    applyStimulus(16'h0030, 16'h0000, 4'd8, 4'd8, 1'b0, 1'b0);
    applyStimulus(16'h0100, 16'hFFFF, 4'd8, 4'd8, 1'b0, 1'b1);
    checkValue("rst_mid_err", {15'd0, errFlag}, 16'd0);
    checkValue("rst_mid_count", {8'd0, wrCount}, 16'd0);
    checkValue("rst_mid_rdA", rdDataA, 16'h0000);
    checkValue("rst_mid_rdB", rdDataB, 16'h0000);
    applyStimulus(16'h0000, 16'h0000, 4'd8, 4'd8, 1'b0, 1'b0);
    checkValue("rst_mid_reg8", rdDataA, 16'h0000);
    checkValue("rst_mid_count_after", {8'd0, wrCount}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
